// File: rtl/cone_pattern_driver_if.sv
// Cone stimulus bus: run control, seed loading, vector out, cone response in,
// and run status / signature back to the harness.
interface cone_pattern_driver_if #(
   parameter int VEC_W = 37
);
   logic             start;
   logic             seed_load;
   logic [VEC_W-1:0] seed_in;
   logic [VEC_W-1:0] vec_out;
   logic             vec_valid;
   logic             resp_in;
   logic             busy;
   logic             done;
   logic [31:0]      signature;
   logic [15:0]      pat_count;

   // harness side: drives control and the cone response
   modport master (
      output start, seed_load, seed_in, resp_in,
      input  vec_out, vec_valid, busy, done, signature, pat_count
   );

   // pattern driver side
   modport slave (
      input  start, seed_load, seed_in, resp_in,
      output vec_out, vec_valid, busy, done, signature, pat_count
   );
endinterface

// File: rtl/cone_pattern_driver.sv
// LFSR pattern source and MISR response compactor for 37-input single-output
// test cones. A run issues NUM_PATTERNS vectors, waits for the last response
// to come back through the RESP_LAT alignment pipe, then pulses done.
module cone_pattern_driver #(
   parameter int               VEC_W        = 37,
   parameter logic [VEC_W-1:0] SEED         = {{(VEC_W-1){1'b0}}, 1'b1},
   parameter int               NUM_PATTERNS = 1024,
   parameter int               RESP_LAT     = 0,
   parameter logic [31:0]      MISR_POLY    = 32'h04C11DB7
) (
   input  logic                  clk,
   input  logic                  rst,
   cone_pattern_driver_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   lfsr_q, lfsr_d;
   logic [VEC_W-1:0]   vec_out_q, vec_out_d;
   logic [31:0]        sig_q, sig_d;
   logic [15:0]        pat_count_q, pat_count_d;
   // [0] is vec_valid itself; [RESP_LAT] marks the cycle resp_in belongs to a vector
   logic [RESP_LAT:0]  vld_pipe_q, vld_pipe_d;

   logic               vec_valid_d;
   logic               rvalid;
   logic               drain_empty;
   logic               last_vec;
   logic               lfsr_fb;
   logic [VEC_W-1:0]   lfsr_next;

   assign rvalid    = vld_pipe_q[RESP_LAT];
   assign lfsr_fb   = ^{lfsr_q[VEC_W-1], lfsr_q[4:0]};
   assign lfsr_next = {lfsr_q[VEC_W-2:0], lfsr_fb};
   // true while issuing the final vector of the run
   assign last_vec  = ({1'b0, pat_count_q} + 17'd1) >= 17'(NUM_PATTERNS);

   // Drain finishes on the cycle the final response is consumed: nothing is
   // left in the stages ahead of the sampling stage.
   always_comb begin
      drain_empty = 1'b1;
      for (int k = 0; k < RESP_LAT; k++) begin
         if (vld_pipe_q[k]) drain_empty = 1'b0;
      end
   end

   // Next-state, LFSR/MISR update and vector issue
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      vec_out_d   = vec_out_q;
      sig_d       = sig_q;
      pat_count_d = pat_count_q;
      vec_valid_d = 1'b0;

      // compaction runs independently of the FSM phase (RUN and DRAIN both feed it)
      if (rvalid) begin
         sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0)
               ^ {31'b0, bus.resp_in};
      end

      case (state_q)
         S_IDLE: begin
            // seed is loaded before start is acted on, so a same-cycle
            // load+start runs from the new seed
            if (bus.seed_load) begin
               lfsr_d = (bus.seed_in == '0) ? {{(VEC_W-1){1'b0}}, 1'b1} : bus.seed_in;
            end
            if (bus.start) begin
               state_d     = S_RUN;
               sig_d       = 32'h0;
               pat_count_d = 16'h0;
            end
         end
         S_RUN: begin
            vec_out_d   = lfsr_q;
            vec_valid_d = 1'b1;
            lfsr_d      = lfsr_next;
            pat_count_d = (pat_count_q == 16'hFFFF) ? pat_count_q : pat_count_q + 16'd1;
            if (last_vec) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_empty) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      vld_pipe_d[0] = vec_valid_d;
      for (int k = 1; k <= RESP_LAT; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
      end
   end

   // State registers; reset aborts any run without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lfsr_q      <= SEED;
         vec_out_q   <= '0;
         sig_q       <= 32'h0;
         pat_count_q <= 16'h0;
         vld_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         vec_out_q   <= vec_out_d;
         sig_q       <= sig_d;
         pat_count_q <= pat_count_d;
         vld_pipe_q  <= vld_pipe_d;
      end
   end

   assign bus.vec_out   = vec_out_q;
   assign bus.vec_valid = vld_pipe_q[0];
   assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.signature = sig_q;
   assign bus.pat_count = pat_count_q;

endmodule

// File: tb/tb_cone_pattern_driver.sv
// Directed bench for cone_pattern_driver: vector sequence, done timing,
// MISR signatures, seed handling, start/reset robustness, and a golden vs
// revised cone comparison.
module tb_cone_pattern_driver;
   localparam int W = 37;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   cone_pattern_driver_if #(.VEC_W(W)) if0 ();
   cone_pattern_driver_if #(.VEC_W(W)) if1 ();
   cone_pattern_driver_if #(.VEC_W(W)) if2 ();
   cone_pattern_driver_if #(.VEC_W(W)) if3 ();
   cone_pattern_driver_if #(.VEC_W(W)) if4 ();

   cone_pattern_driver #(.NUM_PATTERNS(3),    .RESP_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
   cone_pattern_driver #(.NUM_PATTERNS(2),    .RESP_LAT(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
   cone_pattern_driver #(.NUM_PATTERNS(8),    .RESP_LAT(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
   cone_pattern_driver #(.NUM_PATTERNS(8),    .RESP_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
   cone_pattern_driver #(.NUM_PATTERNS(1024), .RESP_LAT(0)) u4 (.clk(clk), .rst(rst), .bus(if4));

   // reference cones: revised is a De Morgan rewrite of golden, bug is not equivalent
   function automatic logic cone_gold(input logic [W-1:0] v);
      return (v[0] & v[1]) ^ (v[2] | v[3]) ^ (^v[36:30]) ^ (v[17] & ~v[9]);
   endfunction
   function automatic logic cone_rev(input logic [W-1:0] v);
      return (~(~v[0] | ~v[1])) ^ (~(~v[2] & ~v[3])) ^ (^v[36:30]) ^ ~(~v[17] | v[9]);
   endfunction
   function automatic logic cone_bug(input logic [W-1:0] v);
      return (v[0] & v[1]) ^ (v[2] ^ v[3]) ^ (^v[36:30]) ^ (v[17] & ~v[9]);
   endfunction
   function automatic logic cone_eval(input logic [W-1:0] v, input int mode);
      case (mode)
         1: return cone_gold(v);
         2: return cone_rev(v);
         3: return cone_bug(v);
         default: return v[0];
      endcase
   endfunction

   // expected signature for n vectors from seed, response = cone_eval(vector, mode)
   function automatic logic [31:0] model_sig(input logic [W-1:0] seed, input int n, input int mode);
      logic [W-1:0] l;
      logic [31:0]  s;
      l = seed;
      s = 32'h0;
      for (int i = 0; i < n; i++) begin
         s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {31'b0, cone_eval(l, mode)};
         l = {l[35:0], ^{l[36], l[4:0]}};
      end
      return s;
   endfunction

   // response wiring
   logic       r0 = 1'b0;
   logic       r1 = 1'b0;
   logic [2:0] dly = 3'b0;
   int         cone_mode = 1;
   assign if0.resp_in = r0;
   assign if1.resp_in = r1;
   assign if2.resp_in = if2.vec_out[0];
   always @(posedge clk) dly <= {dly[1:0], if3.vec_out[0]};
   assign if3.resp_in = dly[2];
   assign if4.resp_in = cone_eval(if4.vec_out, cone_mode);

   // done pulse counter for u0
   int dc0 = 0;
   always @(negedge clk) dc0 <= dc0 + int'(if0.done);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic done_of(input int w);
      case (w)
         0: return if0.done;
         1: return if1.done;
         4: return if4.done;
         default: return 1'b0;
      endcase
   endfunction

   // cyc counts cycles since the start cycle; stops on done or budget
   task automatic wait_done(input int w, input int budget, inout int cyc);
      while (!done_of(w) && cyc < budget) begin
         tick(1);
         cyc++;
      end
      if (!done_of(w)) chk("done_timeout", 64'(cyc), 64'(budget + 1));
   endtask

   initial begin
      int cyc, c2, c3, d;
      logic [31:0] sg [1:3];
      {if0.start, if0.seed_load, if0.seed_in} = '0;
      {if1.start, if1.seed_load, if1.seed_in} = '0;
      {if2.start, if2.seed_load, if2.seed_in} = '0;
      {if3.start, if3.seed_load, if3.seed_in} = '0;
      {if4.start, if4.seed_load, if4.seed_in} = '0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;

      // reset state
      chk("rst_vec",   64'(if0.vec_out),   64'h0);
      chk("rst_vv",    64'(if0.vec_valid), 64'h0);
      chk("rst_busy",  64'(if0.busy),      64'h0);
      chk("rst_done",  64'(if0.done),      64'h0);
      chk("rst_sig",   64'(if0.signature), 64'h0);
      chk("rst_pat",   64'(if0.pat_count), 64'h0);

      // T1: three vectors 1,3,6 then done
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      chk("t1_busy", 64'(if0.busy), 64'h1);
      chk("t1_vv0",  64'(if0.vec_valid), 64'h0);
      tick(1);
      chk("t1_vv1",  64'(if0.vec_valid), 64'h1);
      chk("t1_v1",   64'(if0.vec_out),   64'h1);
      tick(1);
      chk("t1_v2",   64'(if0.vec_out),   64'h3);
      tick(1);
      chk("t1_v3",   64'(if0.vec_out),   64'h6);
      chk("t1_pat3", 64'(if0.pat_count), 64'h3);
      tick(1);
      chk("t1_done", 64'(if0.done),      64'h1);
      chk("t1_vvd",  64'(if0.vec_valid), 64'h0);
      chk("t1_hold", 64'(if0.vec_out),   64'h6);
      chk("t1_idle_busy", 64'(if0.busy), 64'h0);
      tick(1);
      chk("t1_done_off", 64'(if0.done),  64'h0);
      chk("t1_dcount",   64'(dc0),       64'h1);
      chk("t1_pat",      64'(if0.pat_count), 64'h3);

      // T4: zero seed becomes 1; seed 5 loaded together with start
      if0.seed_load = 1'b1; if0.seed_in = '0; tick(1); if0.seed_load = 1'b0;
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      tick(1);
      chk("t4_seed0", 64'(if0.vec_out), 64'h1);
      cyc = 2; wait_done(0, 20, cyc); tick(1);
      if0.seed_load = 1'b1; if0.seed_in = 37'h5; if0.start = 1'b1;
      tick(1);
      if0.seed_load = 1'b0; if0.start = 1'b0;
      tick(1);
      chk("t4_s5_v1", 64'(if0.vec_out), 64'h5);
      tick(1);
      chk("t4_s5_v2", 64'(if0.vec_out), 64'hA);
      cyc = 3; wait_done(0, 20, cyc); tick(1);

      // T5a: start pulsed mid-run leaves latency and count alone
      d = dc0;
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      cyc = 1;
      tick(1); cyc++;
      if0.start = 1'b1; tick(1); if0.start = 1'b0; cyc++;
      wait_done(0, 20, cyc);
      chk("t5_lat", 64'(cyc), 64'd5);
      tick(2);
      chk("t5_pat",    64'(if0.pat_count), 64'h3);
      chk("t5_dcount", 64'(dc0 - d), 64'h1);

      // T5b: reset mid-run aborts with no done pulse
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      tick(1);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("t5_rst_vec",  64'(if0.vec_out),   64'h0);
      chk("t5_rst_vv",   64'(if0.vec_valid), 64'h0);
      chk("t5_rst_busy", 64'(if0.busy),      64'h0);
      chk("t5_rst_sig",  64'(if0.signature), 64'h0);
      chk("t5_rst_pat",  64'(if0.pat_count), 64'h0);
      d = dc0;
      tick(8);
      chk("t5_rst_nodone", 64'(dc0 - d), 64'h0);
      if0.start = 1'b1; tick(1); if0.start = 1'b0;
      tick(1);
      chk("t5_rst_seed", 64'(if0.vec_out), 64'h1);
      cyc = 2; wait_done(0, 20, cyc); tick(1);

      // T2: tied-1 and tied-0 responses, 2 patterns
      r1 = 1'b1;
      if1.start = 1'b1; tick(1); if1.start = 1'b0;
      cyc = 1; wait_done(1, 20, cyc);
      chk("t2_lat",  64'(cyc), 64'd4);
      chk("t2_sig1", 64'(if1.signature), 64'h3);
      chk("t2_pat",  64'(if1.pat_count), 64'h2);
      tick(1);
      r1 = 1'b0;
      if1.start = 1'b1; tick(1); if1.start = 1'b0;
      cyc = 1; wait_done(1, 20, cyc);
      chk("t2_sig0", 64'(if1.signature), 64'h0);
      tick(1);

      // T3: RESP_LAT=3 with delayed response matches the undelayed run
      if2.start = 1'b1; if3.start = 1'b1; tick(1); if2.start = 1'b0; if3.start = 1'b0;
      cyc = 1; c2 = 0; c3 = 0;
      while ((c2 == 0 || c3 == 0) && cyc < 40) begin
         if (if2.done && c2 == 0) c2 = cyc;
         if (if3.done && c3 == 0) c3 = cyc;
         if (c2 == 0 || c3 == 0) begin
            tick(1);
            cyc++;
         end
      end
      chk("t3_lat0", 64'(c2), 64'd10);
      chk("t3_lat3", 64'(c3), 64'd13);
      chk("t3_sig0", 64'(if2.signature), 64'(model_sig(37'h1, 8, 0)));
      chk("t3_sig3", 64'(if3.signature), 64'(model_sig(37'h1, 8, 0)));
      tick(1);

      // T6: golden, revised and buggy cones, 1024 patterns from seed 1
      for (int m = 1; m <= 3; m++) begin
         cone_mode = m;
         if4.seed_load = 1'b1; if4.seed_in = 37'h1; tick(1); if4.seed_load = 1'b0;
         if4.start = 1'b1; tick(1); if4.start = 1'b0;
         cyc = 1; wait_done(4, 1100, cyc);
         chk($sformatf("t6_lat_m%0d", m), 64'(cyc), 64'd1026);
         chk($sformatf("t6_sig_m%0d", m), 64'(if4.signature), 64'(model_sig(37'h1, 1024, m)));
         sg[m] = if4.signature;
         tick(1);
      end
      chk("t6_equiv_match",    64'(sg[2] == sg[1]), 64'h1);
      chk("t6_nonequiv_diff",  64'(sg[3] != sg[1]), 64'h1);
      chk("t6_pat",            64'(if4.pat_count),  64'd1024);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
